pll_supervisor: RTL and testbench

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_supervisor_pkg.sv | 14 +
 rtl/pll_supervisor_ce_divider.sv | 37 +++
 rtl/pll_supervisor.sv | 125 ++++++++++++
 tb/tb_pll_supervisor.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL supervisor: FSM state encoding and
// loss statistics width.
package pll_supervisor_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  localparam int LOSS_W = 8;

endpackage

// File: rtl/pll_supervisor_ce_divider.sv
// Per-channel clock-enable divider: counts RUN cycles 0..div-1 and pulses ce
// on terminal count; a load restarts the period with the new ratio.
module ce_divider #(
  parameter int DIV_W    = 16,
  parameter int DIV_INIT = 25
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  output logic             ce
);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;
  logic             w_term;

  // Ratios 0 and 1 both collapse to "every cycle".
  assign w_term = (r_div <= DIV_W'(1)) || (r_cnt == r_div - DIV_W'(1));
  assign ce     = run & ~load & w_term;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_div <= DIV_W'(DIV_INIT);
      r_cnt <= '0;
    end else if (load) begin
      r_div <= div_in;
      r_cnt <= '0;
    end else if (!run || w_term) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/pll_supervisor.sv
// PLL lock supervisor: qualifies lock over a stability window, releases the
// downstream reset, generates per-channel clock enables and tracks lock losses.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 16,
  parameter int LOCK_STABLE = 1024,
  parameter int DIV_INIT    = 25
) (
  input  logic                    clock_in,
  input  logic                    reset_n,
  input  logic                    locked,
  input  logic [NUM_CH*DIV_W-1:0] div_value,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic                    clear_stats,
  output logic                    sys_rst_n,
  output logic                    ready,
  output logic [NUM_CH-1:0]       ce,
  output logic                    lock_lost,
  output logic [LOSS_W-1:0]       loss_count
);

  localparam int                 STAB_W    = 16;
  localparam logic [STAB_W-1:0]  STAB_LAST = STAB_W'(LOCK_STABLE - 1);
  localparam logic [LOSS_W-1:0]  LOSS_MAX  = '1;

  state_t                         r_state, w_next;
  logic [1:0]                     r_sync;
  logic [STAB_W-1:0]              r_stab_cnt;
  logic                           r_ready, r_sys_rst_n, r_lock_lost;
  logic [LOSS_W-1:0]              r_loss_count;
  logic                           w_locked_s, w_stab_clr, w_stab_inc, w_loss, w_run;
  logic [NUM_CH-1:0][DIV_W-1:0]   w_div_arr;
  logic [NUM_CH-1:0]              w_ce;

  assign w_locked_s = r_sync[1];
  assign w_run      = (r_state == RUN);
  assign w_loss     = w_run & ~w_locked_s;
  assign w_div_arr  = div_value;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[0], locked};
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= WAIT_LOCK;
      r_stab_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_stab_clr)      r_stab_cnt <= '0;
      else if (w_stab_inc) r_stab_cnt <= r_stab_cnt + STAB_W'(1);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_stab_clr = 1'b0;
    w_stab_inc = 1'b0;
    case (r_state)
      WAIT_LOCK: if (w_locked_s) begin
        w_next     = STABLE;
        w_stab_clr = 1'b1;
      end
      STABLE: begin
        if (!w_locked_s)                   w_next = WAIT_LOCK;
        else if (r_stab_cnt == STAB_LAST)  w_next = RUN;
        else                               w_stab_inc = 1'b1;
      end
      RUN:     if (!w_locked_s) w_next = LOST;
      LOST:    w_next = WAIT_LOCK;
      default: w_next = WAIT_LOCK;
    endcase
  end

  // Ready is registered from "RUN now and RUN next" so it rises one cycle
  // after RUN entry but drops on the same edge RUN is left.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_ready     <= 1'b0;
      r_sys_rst_n <= 1'b0;
    end else begin
      r_ready     <= w_run && (w_next == RUN);
      r_sys_rst_n <= w_run && (w_next == RUN);
    end
  end

  // A loss coinciding with clear_stats counts as the first loss after clear.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_lost  <= 1'b0;
      r_loss_count <= '0;
    end else if (w_loss) begin
      r_lock_lost <= 1'b1;
      if (clear_stats)                r_loss_count <= LOSS_W'(1);
      else if (r_loss_count != LOSS_MAX) r_loss_count <= r_loss_count + LOSS_W'(1);
    end else if (clear_stats) begin
      r_lock_lost  <= 1'b0;
      r_loss_count <= '0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    ce_divider #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT)
    ) u_div (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .run      (w_run),
      .load     (div_load[g]),
      .div_in   (w_div_arr[g]),
      .ce       (w_ce[g])
    );
  end

  assign ce         = w_ce;
  assign ready      = r_ready;
  assign sys_rst_n  = r_sys_rst_n;
  assign lock_lost  = r_lock_lost;
  assign loss_count = r_loss_count;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed scenarios plus random traffic, every
// cycle compared against a streak/phase based reference model.
module tb_pll_supervisor;
  localparam int NCH = 4, DW = 16, LS = 16, DINIT = 25;

  logic clock_in = 1'b0, reset_n = 1'b0, locked = 1'b0, clear_stats = 1'b0;
  logic [NCH*DW-1:0] div_value = '0;
  logic [NCH-1:0]    div_load = '0;
  logic              sys_rst_n, ready, lock_lost;
  logic [NCH-1:0]    ce;
  logic [7:0]        loss_count;

  pll_supervisor #(.NUM_CH(NCH), .DIV_W(DW), .LOCK_STABLE(LS), .DIV_INIT(DINIT)) dut (
    .clock_in(clock_in), .reset_n(reset_n), .locked(locked), .div_value(div_value),
    .div_load(div_load), .clear_stats(clear_stats), .sys_rst_n(sys_rst_n),
    .ready(ready), .ce(ce), .lock_lost(lock_lost), .loss_count(loss_count));

  always #5 clock_in = ~clock_in;

  int total = 0, bad = 0;

  // Reference model: lock qualified as a streak of synchronised-high samples,
  // channels as RUN-cycle phase within the current ratio.
  int m_hist[$];
  bit m_run, m_ready, m_lost;
  int m_hold, m_streak, m_lcnt;
  int m_div[NCH], m_ph[NCH];
  logic [NCH-1:0] last_ce;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = {0, 0};
    m_run = 0; m_ready = 0; m_lost = 0;
    m_hold = 0; m_streak = 0; m_lcnt = 0;
    for (int i = 0; i < NCH; i++) begin m_div[i] = DINIT; m_ph[i] = 0; end
  endtask

  function automatic bit m_term(int i);
    return (m_div[i] <= 1) || (m_ph[i] == m_div[i] - 1);
  endfunction

  task automatic model_update(input bit lk, input logic [NCH-1:0] ld,
                              input logic [NCH*DW-1:0] dv, input bit clr);
    bit ls, was_run;
    ls = (m_hist[0] != 0);
    was_run = m_run;
    for (int i = 0; i < NCH; i++) begin
      if (ld[i]) begin m_div[i] = int'(dv[i*DW +: DW]); m_ph[i] = 0; end
      else if (was_run && !m_term(i)) m_ph[i]++;
      else m_ph[i] = 0;
    end
    if (was_run && !ls) begin
      m_lost = 1;
      m_lcnt = clr ? 1 : (m_lcnt < 255 ? m_lcnt + 1 : 255);
    end else if (clr) begin
      m_lost = 0; m_lcnt = 0;
    end
    if (m_run) begin
      if (!ls) begin m_run = 0; m_hold = 1; m_streak = 0; end
    end else if (m_hold > 0) begin
      m_hold--; m_streak = 0;
    end else begin
      m_streak = ls ? m_streak + 1 : 0;
      if (m_streak == LS + 1) begin m_run = 1; m_streak = 0; end
    end
    m_ready = was_run && m_run;
    void'(m_hist.pop_front());
    m_hist.push_back(int'(lk));
  endtask

  // One clock: drive at negedge, check, advance model at posedge.
  task automatic step(input bit lk, input logic [NCH-1:0] ld,
                      input logic [NCH*DW-1:0] dv, input bit clr);
    logic [NCH-1:0] exp_ce;
    locked = lk; div_load = ld; div_value = dv; clear_stats = clr;
    #1;
    for (int i = 0; i < NCH; i++) exp_ce[i] = m_run && !ld[i] && m_term(i);
    chk("ce", 32'(ce), 32'(exp_ce));
    chk("ready", 32'(ready), 32'(m_ready));
    chk("sys_rst_n", 32'(sys_rst_n), 32'(m_ready));
    chk("lock_lost", 32'(lock_lost), 32'(m_lost));
    chk("loss_count", 32'(loss_count), 32'(m_lcnt));
    last_ce = ce;
    @(posedge clock_in);
    model_update(lk, ld, dv, clr);
    @(negedge clock_in);
  endtask

  task automatic tick(input bit lk);
    step(lk, '0, div_value, 1'b0);
  endtask

  task automatic load(input int ch, input int val);
    logic [NCH*DW-1:0] dv;
    logic [NCH-1:0] ld;
    dv = div_value; dv[ch*DW +: DW] = DW'(val);
    ld = '0; ld[ch] = 1'b1;
    step(1'b1, ld, dv, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin tick(1'b1); n++; end
  endtask

  task automatic cnt_ce(input int ch, output int n);
    n = 0;
    do begin tick(1'b1); n++; end while (!last_ce[ch] && n < 100);
  endtask

  task automatic drop_relock(input bit clr_on_loss);
    int n;
    n = 0;
    while (m_run && n < 10) begin
      step(1'b0, '0, div_value, clr_on_loss && (m_hist[0] == 0));
      n++;
    end
    wait_ready(n);
    chk("relock", 32'(ready), 32'd1);
  endtask

  initial begin
    int n, k;
    logic [NCH-1:0] ld;
    logic [NCH*DW-1:0] dv;
    model_reset();
    repeat (3) @(posedge clock_in);
    @(negedge clock_in);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_sys", 32'(sys_rst_n), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_lost", 32'(lock_lost), 32'd0);
    chk("rst_cnt", 32'(loss_count), 32'd0);
    reset_n = 1'b1;

    // Lock latency: 2 sync + 1 + LOCK_STABLE + 1
    wait_ready(n);
    chk("lock_latency", n, LS + 4);

    // Glitch at stable count 10 restarts the window
    repeat (6) tick(1'b0);
    repeat (11) tick(1'b1);
    tick(1'b0);
    wait_ready(n);
    chk("glitch_latency", n, LS + 4);

    // Divider period and mid-period reload
    load(0, 4);
    cnt_ce(0, n); chk("div4_first", n, 4);
    cnt_ce(0, n); chk("div4_period", n, 4);
    tick(1'b1); tick(1'b1);
    load(0, 3);
    cnt_ce(0, n); chk("reload3", n, 3);

    // Loss statistics, clear vs coincident loss, saturation
    step(1'b1, '0, div_value, 1'b1);
    repeat (3) drop_relock(1'b0);
    chk("loss3", 32'(loss_count), 32'd3);
    drop_relock(1'b1);
    chk("clr_loss_flag", 32'(lock_lost), 32'd1);
    chk("clr_loss_cnt", 32'(loss_count), 32'd1);
    step(1'b1, '0, div_value, 1'b1);
    chk("clear_cnt", 32'(loss_count), 32'd0);
    repeat (300) drop_relock(1'b0);
    chk("saturate", 32'(loss_count), 32'd255);

    // div 0/1 channels fire every RUN cycle; loss quiets everything
    dv = div_value; dv[1*DW +: DW] = '0; dv[2*DW +: DW] = DW'(1);
    step(1'b1, 4'b0110, dv, 1'b0);
    k = 0;
    for (int i = 0; i < 8; i++) begin tick(1'b1); if (last_ce[2:1] == 2'b11) k++; end
    chk("div01_every", k, 8);
    repeat (3) tick(1'b0);
    chk("loss_ce", 32'(ce), 32'd0);
    chk("loss_sys", 32'(sys_rst_n), 32'd0);
    wait_ready(n);

    // Asynchronous reset mid-RUN, div registers back to init
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", 32'(ready), 32'd0);
    chk("arst_sys", 32'(sys_rst_n), 32'd0);
    chk("arst_ce", 32'(ce), 32'd0);
    chk("arst_lost", 32'(lock_lost), 32'd0);
    chk("arst_cnt", 32'(loss_count), 32'd0);
    model_reset();
    repeat (2) @(posedge clock_in);
    @(negedge clock_in);
    reset_n = 1'b1;
    wait_ready(n);
    chk("arst_relock", n, LS + 4);
    cnt_ce(0, n);
    chk("div_init", n, DINIT - 1);
    chk("div_init_all", 32'(last_ce), 32'hF);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      dv = div_value; ld = '0;
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 15) == 0) begin
          ld[i] = 1'b1; dv[i*DW +: DW] = DW'($urandom_range(0, 9));
        end
      step($urandom_range(0, 59) != 0, ld, dv, $urandom_range(0, 39) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
